jtframe_ram_upload: RTL and testbench

//  Reader side of the ROM/RAM load path: serves SDRAM contents back to the ARM io controller during
//  an NVRAM/RAM upload (ioctl_ram high). Converts byte requests on ioctl_addr into 16-bit SDRAM reads

---
 rtl/jtframe_ram_upload.sv | 230 +++++++++++++++++++++++
 tb/tb_jtframe_ram_upload.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_ram_upload.sv
// Serves SDRAM contents to the io controller byte by byte during a RAM upload (ioctl_ram high).
// Optional macro JTFRAME_UPLOAD_PREFETCH_EN adds a second buffer that prefetches the following word.
module jtframe_ram_upload #(
    parameter logic [1:0]  BA        = 2'd0,
    parameter logic [24:0] OFFSET    = 25'd0,
    parameter int          RAM_BYTES = 8192
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        ioctl_ram,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_data2sd,
    output logic        data_ok,
    output logic [21:0] prog_addr,
    output logic [1:0]  prog_ba,
    output logic        prog_rd,
    input  logic        prog_ack,
    input  logic        prog_rdy,
    input  logic [15:0] sdram_dout
);
    localparam logic [24:0] WIN_BYTES = 25'(RAM_BYTES);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, PF_REQ, PF_WAIT} state_t;
    state_t state, state_nx;

    logic [24:0] rel;
    logic [21:0] word;
    logic        in_range;
    logic        ram_l;
    logic        drop;
    logic        keep;
    logic        hit;
    logic [15:0] hit_buf;

    logic [15:0] buf_a;
    logic [21:0] tag_a;
    logic        valid_a;
    logic        hit_a;
    logic        issue_req;
    logic        fill_a;

    assign rel      = ioctl_addr - OFFSET;
    assign word     = rel[22:1];
    assign in_range = (ioctl_addr >= OFFSET) && (rel < WIN_BYTES);
    assign prog_ba  = BA;

    // Buffers are ignored on the first cycle of a session, before the invalidation lands.
    assign hit_a = valid_a && ram_l && (tag_a == word);
    // Read data is only kept if the session that issued it is still the current one.
    assign keep  = ioctl_ram && ram_l && !drop;

`ifdef JTFRAME_UPLOAD_PREFETCH_EN
    localparam logic [21:0] WIN_WORDS = 22'((RAM_BYTES + 1) / 2);

    logic [15:0] buf_b;
    logic [21:0] tag_b;
    logic        valid_b;
    logic        hit_b;
    logic [21:0] pf_word;
    logic        pf_pend;
    logic        issue_pf;
    logic        fill_b;
    logic        swap;

    assign hit_b   = valid_b && ram_l && (tag_b == word);
    assign hit     = hit_a || hit_b;
    assign hit_buf = hit_a ? buf_a : buf_b;
`else
    assign hit     = hit_a;
    assign hit_buf = buf_a;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        issue_req = 1'b0;
        fill_a    = 1'b0;
`ifdef JTFRAME_UPLOAD_PREFETCH_EN
        issue_pf  = 1'b0;
        fill_b    = 1'b0;
        swap      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (ioctl_ram && ram_l && in_range && !hit) begin
                    issue_req = 1'b1;
                    state_nx  = REQ;
                end
`ifdef JTFRAME_UPLOAD_PREFETCH_EN
                else if (ioctl_ram && ram_l && in_range && hit_b && !hit_a) begin
                    swap = 1'b1;
                end else if (ioctl_ram && ram_l && pf_pend && (pf_word < WIN_WORDS)) begin
                    issue_pf = 1'b1;
                    state_nx = PF_REQ;
                end
`endif
            end
            REQ: begin
                // ack and rdy together: the access is complete in one step
                if (prog_ack) begin
                    if (prog_rdy) begin
                        fill_a   = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (prog_rdy) begin
                    fill_a   = 1'b1;
                    state_nx = IDLE;
                end
            end
`ifdef JTFRAME_UPLOAD_PREFETCH_EN
            PF_REQ: begin
                if (prog_ack) begin
                    if (prog_rdy) begin
                        fill_b   = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = PF_WAIT;
                    end
                end
            end
            PF_WAIT: begin
                if (prog_rdy) begin
                    fill_b   = 1'b1;
                    state_nx = IDLE;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_l         <= 1'b0;
            drop          <= 1'b0;
            prog_rd       <= 1'b0;
            prog_addr     <= '0;
            buf_a         <= '0;
            tag_a         <= '0;
            valid_a       <= 1'b0;
            ioctl_data2sd <= 8'h00;
            data_ok       <= 1'b0;
`ifdef JTFRAME_UPLOAD_PREFETCH_EN
            buf_b         <= '0;
            tag_b         <= '0;
            valid_b       <= 1'b0;
            pf_word       <= '0;
            pf_pend       <= 1'b0;
`endif
        end else begin
            ram_l <= ioctl_ram;

            // A session edge while an access is in flight marks its result as stale.
            if (state == IDLE)           drop <= 1'b0;
            else if (ioctl_ram != ram_l) drop <= 1'b1;

            // prog_addr only moves on issue, so it is stable for the whole handshake.
            if (issue_req) begin
                prog_addr <= word;
                prog_rd   <= 1'b1;
            end
`ifdef JTFRAME_UPLOAD_PREFETCH_EN
            else if (issue_pf) begin
                prog_addr <= pf_word;
                prog_rd   <= 1'b1;
                pf_pend   <= 1'b0;
            end
`endif
            else if (prog_rd && prog_ack) begin
                prog_rd <= 1'b0;
            end

            if (fill_a && keep) begin
                buf_a   <= sdram_dout;
                tag_a   <= prog_addr;
                valid_a <= 1'b1;
`ifdef JTFRAME_UPLOAD_PREFETCH_EN
                pf_pend <= 1'b1;
                pf_word <= prog_addr + 22'd1;
`endif
            end

`ifdef JTFRAME_UPLOAD_PREFETCH_EN
            if (fill_b && keep) begin
                buf_b   <= sdram_dout;
                tag_b   <= prog_addr;
                valid_b <= 1'b1;
            end
            if (swap) begin
                buf_a   <= buf_b;
                tag_a   <= tag_b;
                valid_a <= 1'b1;
                valid_b <= 1'b0;
                pf_pend <= 1'b1;
                pf_word <= tag_b + 22'd1;
            end
`endif

            if (ioctl_ram != ram_l) begin
                valid_a <= 1'b0;
`ifdef JTFRAME_UPLOAD_PREFETCH_EN
                valid_b <= 1'b0;
                pf_pend <= 1'b0;
`endif
            end

            if (!ioctl_ram) begin
                data_ok <= 1'b0;
            end else if (!in_range) begin
                ioctl_data2sd <= 8'hFF;
                data_ok       <= 1'b1;
            end else if (hit) begin
                ioctl_data2sd <= rel[0] ? hit_buf[15:8] : hit_buf[7:0];
                data_ok       <= 1'b1;
            end else begin
                data_ok <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_ram_upload.sv
// Directed bench for jtframe_ram_upload with a small SDRAM responder of programmable ack/rdy delay.
module tb_jtframe_ram_upload;
    localparam logic [24:0] OFS = 25'h100;
    localparam int          RB  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        ioctl_ram;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data2sd;
    logic        data_ok;
    logic [21:0] prog_addr;
    logic [1:0]  prog_ba;
    logic        prog_rd;
    logic        prog_ack   = 1'b0;
    logic        prog_rdy   = 1'b0;
    logic [15:0] sdram_dout = 16'h0000;

    always #5 clk = ~clk;

    jtframe_ram_upload #(.BA(2'd1), .OFFSET(OFS), .RAM_BYTES(RB)) dut (
        .clk(clk), .rst(rst), .ioctl_ram(ioctl_ram), .ioctl_addr(ioctl_addr),
        .ioctl_data2sd(ioctl_data2sd), .data_ok(data_ok), .prog_addr(prog_addr),
        .prog_ba(prog_ba), .prog_rd(prog_rd), .prog_ack(prog_ack), .prog_rdy(prog_rdy),
        .sdram_dout(sdram_dout)
    );

    logic [15:0] mem [0:31];
    int          ack_dly = 3;
    int          rdy_dly = 5;
    int          cnt     = 0;
    bit          busy    = 1'b0;
    logic [21:0] req_a   = '0;
    int          nreads  = 0;
    logic [21:0] rlog [$];
    logic [21:0] last_addr = '0;
    logic        last_rd   = 1'b0;
    int          unstable  = 0;

    // SDRAM responder: counts cycles from request pickup, pulses ack then rdy.
    always @(negedge clk) begin
        prog_ack = 1'b0;
        prog_rdy = 1'b0;
        if (rst) begin
            busy = 1'b0;
        end else if (busy) begin
            cnt++;
            if (cnt == ack_dly) prog_ack = 1'b1;
            if (cnt == rdy_dly) begin
                prog_rdy   = 1'b1;
                sdram_dout = mem[req_a[4:0]];
                busy       = 1'b0;
            end
        end else if (prog_rd) begin
            busy  = 1'b1;
            cnt   = 0;
            req_a = prog_addr;
            nreads++;
            rlog.push_back(prog_addr);
        end
        if (prog_rd && last_rd && prog_addr != last_addr) unstable++;
        last_rd   = prog_rd;
        last_addr = prog_addr;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_ok(input string tag);
        for (int i = 0; i < 80 && !data_ok; i++) tick();
        if (!data_ok) check({tag, " data_ok timeout"}, 32'(data_ok), 1);
    endtask

    task automatic wait_rd(input logic v, input string tag);
        for (int i = 0; i < 80 && prog_rd !== v; i++) tick();
        if (prog_rd !== v) check({tag, " prog_rd timeout"}, 32'(prog_rd), 32'(v));
    endtask

    int n0;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'(i * 16'h0101);
        mem[0]  = 16'hA55A;
        mem[1]  = 16'h1234;
        mem[2]  = 16'h5678;
        mem[3]  = 16'hDEAD;
        mem[5]  = 16'h9ABC;
        mem[31] = 16'hC37E;

        rst = 1'b1; ioctl_ram = 1'b0; ioctl_addr = OFS;
        tick(3);
        check("reset prog_rd",   32'(prog_rd), 0);
        check("reset data_ok",   32'(data_ok), 0);
        check("reset data",      32'(ioctl_data2sd), 0);
        check("reset prog_addr", 32'(prog_addr), 0);
        check("prog_ba",         32'(prog_ba), 1);
        rst = 1'b0;

        // reset while a request is outstanding
        ack_dly = 20; rdy_dly = 22;
        ioctl_ram = 1'b1; ioctl_addr = OFS + 25'd4;
        wait_rd(1'b1, "t1");
        check("t1 prog_addr", 32'(prog_addr), 2);
        rst = 1'b1;
        tick();
        check("t1 prog_rd", 32'(prog_rd), 0);
        check("t1 data_ok", 32'(data_ok), 0);
        check("t1 data",    32'(ioctl_data2sd), 0);
        rst = 1'b0; ioctl_ram = 1'b0;
        tick(2);

        // first access, then odd byte from the same word
        ack_dly = 3; rdy_dly = 5;
        n0 = nreads;
        ioctl_ram = 1'b1; ioctl_addr = OFS;
        tick();
        wait_ok("t2");
        check("t2 byte0", 32'(ioctl_data2sd), 'h5A);
        check("t2 word0", 32'(rlog[$]), 0);
`ifndef JTFRAME_UPLOAD_PREFETCH_EN
        check("t2 reads", nreads - n0, 1);
`endif
        ioctl_addr = OFS + 25'd1;
        tick();
        check("t2 byte1",    32'(ioctl_data2sd), 'hA5);
        check("t2 byte1 ok", 32'(data_ok), 1);
`ifndef JTFRAME_UPLOAD_PREFETCH_EN
        check("t2 no reread", nreads - n0, 1);
`endif

        // window boundaries
        tick(10);
        n0 = nreads;
        ioctl_addr = OFS + 25'(RB);
        tick();
        check("t3 above data", 32'(ioctl_data2sd), 'hFF);
        check("t3 above ok",   32'(data_ok), 1);
        ioctl_addr = OFS - 25'd1;
        tick(5);
        check("t3 below data", 32'(ioctl_data2sd), 'hFF);
        check("t3 below ok",   32'(data_ok), 1);
`ifndef JTFRAME_UPLOAD_PREFETCH_EN
        check("t3 no reads", nreads - n0, 0);
`endif
        ioctl_addr = OFS + 25'(RB - 1);
        tick();
        wait_ok("t3 last");
        check("t3 last byte", 32'(ioctl_data2sd), 'hC3);
        check("t3 last word", 32'(rlog[$]), 31);

        // ack and rdy in the same cycle
        tick(10);
        ack_dly = 4; rdy_dly = 4;
        ioctl_addr = OFS + 25'd6;
        tick();
        wait_ok("t4a");
        check("ackrdy byte", 32'(ioctl_data2sd), 'hAD);

        // address moves while the read is waiting for data
        tick(10);
        ack_dly = 2; rdy_dly = 8;
        n0 = nreads;
        ioctl_addr = OFS + 25'd2;
        wait_rd(1'b1, "t4 req");
        wait_rd(1'b0, "t4 ack");
        ioctl_addr = OFS + 25'd4;
        tick();
        wait_ok("t4");
        check("t4 byte", 32'(ioctl_data2sd), 'h78);
`ifndef JTFRAME_UPLOAD_PREFETCH_EN
        check("t4 reads", nreads - n0, 2);
        check("t4 first word",  32'(rlog[$-1]), 1);
        check("t4 second word", 32'(rlog[$]), 2);
`endif

        // session closed while the read is waiting for data
        tick(10);
        n0 = nreads;
        ioctl_addr = OFS + 25'd10;
        wait_rd(1'b1, "t5 req");
        wait_rd(1'b0, "t5 ack");
        ioctl_ram = 1'b0;
        tick(12);
        check("t5 data_ok", 32'(data_ok), 0);
        check("t5 prog_rd", 32'(prog_rd), 0);
        check("t5 rdy consumed", 32'(busy), 0);
`ifndef JTFRAME_UPLOAD_PREFETCH_EN
        check("t5 reads", nreads - n0, 1);
`endif
        ioctl_ram = 1'b1; ioctl_addr = OFS + 25'd4;
        tick();
        wait_ok("t5 reopen");
        check("t5 reopen byte", 32'(ioctl_data2sd), 'h78);
`ifndef JTFRAME_UPLOAD_PREFETCH_EN
        check("t5 reopen misses", nreads - n0, 2);
`endif

`ifdef JTFRAME_UPLOAD_PREFETCH_EN
        begin
            int base;
            int low;
            ioctl_ram = 1'b0;
            tick(12);
            ack_dly = 2; rdy_dly = 4;
            base = rlog.size();
            low  = 0;
            ioctl_ram = 1'b1;
            for (int a = 0; a < 8; a++) begin
                ioctl_addr = OFS + 25'(a);
                for (int k = 0; k < 12; k++) begin
                    tick();
                    if (a >= 2 && !data_ok) low++;
                end
            end
            check("pf data_ok low", low, 0);
            check("pf read count", rlog.size() - base, 5);
            for (int w = 0; w < 5 && base + w < rlog.size(); w++)
                check("pf read order", 32'(rlog[base + w]), w);
            check("pf last byte", 32'(ioctl_data2sd), 'hDE);
        end
`endif

        check("prog_addr stable", unstable, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

endmodule
